// File: rtl/weight_stream_tx.sv
// Serial weight-load transmitter: takes signed words over valid/ready, shifts each
// out MSB-first with a write strobe and address, and keeps a 16-bit running checksum.
module weight_stream_tx #(
  parameter int WIDTH       = 10,
  parameter int NUM_WEIGHTS = 65,
  parameter int ADDR_W      = 7
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  wData,
  input  logic              wValid,
  output logic              wReady,
  output logic              SerOut,
  output logic              WE,
  output logic [ADDR_W-1:0] Addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where wValid and wReady are both
  // high; wReady is high only in WAIT_WORD and wData is ignored at all other times.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [CW-1:0]     bitcnt;
  logic [15:0]       wdata_sext;

  assign wdata_sext = 16'($signed(wData));

  // Zeros shift in behind the word, so the register is empty whenever WE is low.
  assign SerOut    = shreg[WIDTH-1];
  assign dbg_state = state;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      WE       <= 1'b0;
      Addr     <= '0;
      wReady   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT_WORD;
            busy     <= 1'b1;
            wReady   <= 1'b1;
            Addr     <= '0;
            checksum <= '0;
          end
        end
        WAIT_WORD: begin
          if (wValid) begin
            shreg    <= wData;
            checksum <= checksum + wdata_sext;
            bitcnt   <= '0;
            WE       <= 1'b1;
            wReady   <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg  <= shreg << 1;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            WE <= 1'b0;
            if (Addr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              Addr   <= Addr + 1'b1;
              wReady <= 1'b1;
              state  <= WAIT_WORD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
